// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler.
// Holds the TMDS mode encoding, the island FSM states, the CTL
// preamble patterns and the fixed period lengths.
package hdmi_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_IGUARD = 3'd4
  } tmds_mode_t;

  typedef enum logic [2:0] {
    ST_CTRL      = 3'd0,
    ST_DI_PRE    = 3'd1,
    ST_DI_LGUARD = 3'd2,
    ST_DI_DATA   = 3'd3,
    ST_DI_TGUARD = 3'd4
  } island_state_t;

  localparam logic [3:0] CTL_VIDEO_PREAMBLE  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND_PREAMBLE = 4'b0101;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  // Number of whole packets that fit between the island launch column
  // and the next video preamble, leaving room for the island's own
  // preamble, both guards and the trailing control gap.
  function automatic int maxFit(input int frameWidth, input int screenWidth,
                                input int islandGap);
    return (frameWidth - 10 - islandGap - (screenWidth + islandGap)
            - (PREAMBLE_LEN + 2 * GUARD_LEN)) / PACKET_LEN;
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer.
// Decodes the raster position into control, video preamble/guard/data
// and data-island preamble/guard/packet periods, drives the shared TMDS
// mode select, the CTL preamble bits and the packet handshake toward
// the packet assembler. Every output is registered one clock after the
// cx/cy that produced it.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int ISLAND_GAP    = 4,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  packet_valid,
  output logic                  packet_ready,
  output logic [2:0]            mode,
  output logic [3:0]            ctl,
  output logic [1:0]            sync_out,
  output logic [4:0]            packet_pixel
);

  localparam int MAX_FIT = maxFit(FRAME_WIDTH, SCREEN_WIDTH, ISLAND_GAP);

  // An island that cannot hold even one packet means the raster
  // parameters leave no room for data islands at all.
  if (MAX_FIT < 1) begin : gFitCheck
    $error("hdmi_period_scheduler: MAX_FIT < 1, no room for a data island");
  end

  // Effective packet limit per island: the tighter of the protocol
  // limit and what physically fits before the next video preamble.
  localparam int PKT_LIMIT_I = (MAX_PACKETS < MAX_FIT) ? MAX_PACKETS : MAX_FIT;
  localparam logic [4:0] PKT_LIMIT = 5'(PKT_LIMIT_I);

  // Position constants carry one extra bit so FRAME_WIDTH itself is
  // representable without wrapping.
  localparam logic [BIT_WIDTH:0]  SCREEN_W_C  = (BIT_WIDTH + 1)'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH:0]  LAUNCH_CX   = (BIT_WIDTH + 1)'(SCREEN_WIDTH + ISLAND_GAP);
  localparam logic [BIT_WIDTH:0]  VPRE_START  = (BIT_WIDTH + 1)'(FRAME_WIDTH - 10);
  localparam logic [BIT_WIDTH:0]  VPRE_END    = (BIT_WIDTH + 1)'(FRAME_WIDTH - 3);
  localparam logic [BIT_WIDTH:0]  VGUARD_START = (BIT_WIDTH + 1)'(FRAME_WIDTH - 2);
  localparam logic [BIT_WIDTH:0]  VGUARD_END  = (BIT_WIDTH + 1)'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT:0] SCREEN_H_C  = (BIT_HEIGHT + 1)'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT:0] LAST_LINE   = (BIT_HEIGHT + 1)'(FRAME_HEIGHT - 1);
  localparam logic [BIT_HEIGHT:0] LINE_ONE    = (BIT_HEIGHT + 1)'(1);

  localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] GUARD_LAST = 5'(GUARD_LEN - 1);
  localparam logic [4:0] PKT_LAST   = 5'(PACKET_LEN - 1);

  island_state_t   state_q, state_d;
  logic [4:0]      phase_q, phase_d;
  logic [4:0]      count_q, count_d;
  tmds_mode_t      mode_q, mode_d;
  logic [3:0]      ctl_q, ctl_d;
  logic            ready_q, ready_d;
  logic [4:0]      pixel_q, pixel_d;
  logic [1:0]      sync_q;

  logic [BIT_WIDTH:0]  cxWide;
  logic [BIT_HEIGHT:0] cyWide;
  logic [BIT_HEIGHT:0] nextLine;
  logic                inActive;
  logic                nextActive;
  logic                inVPre;
  logic                inVGuard;

  // Raster decode: active area, and the video preamble/guard that lead
  // into the next line when that line carries active video.
  always_comb begin
    cxWide     = {1'b0, cx};
    cyWide     = {1'b0, cy};
    nextLine   = (cyWide == LAST_LINE) ? '0 : cyWide + LINE_ONE;
    inActive   = (cxWide < SCREEN_W_C) && (cyWide < SCREEN_H_C);
    nextActive = nextLine < SCREEN_H_C;
    inVPre     = nextActive && (cxWide >= VPRE_START) && (cxWide <= VPRE_END);
    inVGuard   = nextActive && (cxWide >= VGUARD_START) && (cxWide <= VGUARD_END);
  end

  // Island sequencing and output selection; video periods override any
  // island state and pull the FSM back to control.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    mode_d  = MODE_CTRL;
    ctl_d   = 4'b0000;
    ready_d = 1'b0;
    pixel_d = 5'd0;

    case (state_q)
      ST_CTRL: begin
        phase_d = 5'd0;
        if (cxWide == LAUNCH_CX && packet_valid) begin
          state_d = ST_DI_PRE;
          count_d = 5'd0;
        end
      end
      ST_DI_PRE: begin
        if (phase_q == PRE_LAST) begin
          state_d = ST_DI_LGUARD;
          phase_d = 5'd0;
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      ST_DI_LGUARD: begin
        if (phase_q == GUARD_LAST) begin
          state_d = ST_DI_DATA;
          phase_d = 5'd0;
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      ST_DI_DATA: begin
        // The handshake on the previous clock already decided whether
        // another packet follows this one.
        if (phase_q == PKT_LAST) begin
          phase_d = 5'd0;
          if (!ready_q) begin
            state_d = ST_DI_TGUARD;
          end
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      ST_DI_TGUARD: begin
        if (phase_q == GUARD_LAST) begin
          state_d = ST_CTRL;
          phase_d = 5'd0;
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_CTRL;
        phase_d = 5'd0;
      end
    endcase

    // First packet is always taken at the end of the leading guard;
    // later ones only while the assembler has one and room remains.
    if (state_d == ST_DI_LGUARD && phase_d == GUARD_LAST) begin
      ready_d = 1'b1;
      count_d = count_q + 5'd1;
    end else if (state_d == ST_DI_DATA && phase_d == PKT_LAST &&
                 packet_valid && count_q < PKT_LIMIT) begin
      ready_d = 1'b1;
      count_d = count_q + 5'd1;
    end

    if (inActive || inVPre || inVGuard) begin
      state_d = ST_CTRL;
      phase_d = 5'd0;
      ready_d = 1'b0;
      if (inActive) begin
        mode_d = MODE_VIDEO;
      end else if (inVPre) begin
        ctl_d = CTL_VIDEO_PREAMBLE;
      end else begin
        mode_d = MODE_VGUARD;
      end
    end else begin
      case (state_d)
        ST_DI_PRE:    ctl_d = CTL_ISLAND_PREAMBLE;
        ST_DI_LGUARD: mode_d = MODE_IGUARD;
        ST_DI_TGUARD: mode_d = MODE_IGUARD;
        ST_DI_DATA: begin
          mode_d  = MODE_ISLAND;
          pixel_d = phase_d;
        end
        default: begin
          mode_d = MODE_CTRL;
        end
      endcase
    end
  end

  // Register FSM state and every output; reset aborts any island.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= ST_CTRL;
      phase_q <= 5'd0;
      count_q <= 5'd0;
      mode_q  <= MODE_CTRL;
      ctl_q   <= 4'b0000;
      ready_q <= 1'b0;
      pixel_q <= 5'd0;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      ctl_q   <= ctl_d;
      ready_q <= ready_d;
      pixel_q <= pixel_d;
      sync_q  <= {vsync, hsync};
    end
  end

  assign mode         = mode_q;
  assign ctl          = ctl_q;
  assign packet_ready = ready_q;
  assign packet_pixel = pixel_q;
  assign sync_out     = sync_q;

endmodule
